// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 line-buffer / conv-kernel datapath: streams a W x H ifmap
// out of SRAM, tracks window completion and writes (W-2)x(H-2) kernel results.
module conv_seq_ctrl #(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int DIMW = 8,
  parameter int KLAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [DIMW-1:0] cfg_width,
  input  logic [DIMW-1:0] cfg_height,
  input  logic [AW-1:0]   cfg_rd_base,
  input  logic [AW-1:0]   cfg_wr_base,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic            ifm_rd_en,
  output logic [AW-1:0]   ifm_rd_addr,
  input  logic [DW-1:0]   ifm_rd_data,
  output logic            lb_push,
  output logic [DW-1:0]   lb_data,
  input  logic [DW-1:0]   conv_dout,
  output logic            ofm_wr_en,
  output logic [AW-1:0]   ofm_wr_addr,
  output logic [DW-1:0]   ofm_wr_data
);

  localparam int CW = 2 * DIMW;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DIMW-1:0]   width_q;
  logic [AW-1:0]     rd_base_q, wr_base_q;
  logic [CW-1:0]     npix_q, nwr_q;
  logic [CW-1:0]     rd_cnt, wr_cnt;
  logic [DIMW-1:0]   col, row;
  logic              push_p0;
  logic              win_p0;
  logic [KLAT-1:0]   win_p1;
  logic              cfg_ok, launch, abort_job, last_wr;

  assign cfg_ok    = (cfg_width >= DIMW'(3)) && (cfg_height >= DIMW'(3));
  assign launch    = (state == IDLE) && start && cfg_ok;
  // Abort is only meaningful for a running job; start wins in IDLE.
  assign abort_job = abort && (state != IDLE);
  assign win_p0    = push_p0 && (row >= DIMW'(2)) && (col >= DIMW'(2));
  assign last_wr   = ofm_wr_en && (wr_cnt == nwr_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ifm_rd_en = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:  if (launch) state_nxt = READ;
      READ: begin
        ifm_rd_en = 1'b1;
        if (rd_cnt == npix_q - CW'(1)) state_nxt = DRAIN;
      end
      DRAIN: if (last_wr) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_job) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      width_q   <= cfg_width;
      rd_base_q <= cfg_rd_base;
      wr_base_q <= cfg_wr_base;
      npix_q    <= CW'(cfg_width) * CW'(cfg_height);
      nwr_q     <= CW'(cfg_width - DIMW'(2)) * CW'(cfg_height - DIMW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= (state == IDLE) && start && !cfg_ok;
  end

  // p0: read issued -> pixel at line buffer; p1: window flag through kernel latency
  always_ff @(posedge clk) begin
    if (rst || abort_job) begin
      push_p0 <= 1'b0;
      win_p1  <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      push_p0 <= ifm_rd_en;
      win_p1  <= (win_p1 << 1) | KLAT'(win_p0);
      if (launch) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
        col    <= '0;
        row    <= '0;
      end
      if (ifm_rd_en) rd_cnt <= rd_cnt + CW'(1);
      if (push_p0) begin
        if (col == width_q - DIMW'(1)) begin
          col <= '0;
          row <= row + DIMW'(1);
        end else begin
          col <= col + DIMW'(1);
        end
      end
      if (ofm_wr_en) wr_cnt <= wr_cnt + CW'(1);
    end
  end

  assign ifm_rd_addr = ifm_rd_en ? rd_base_q + AW'(rd_cnt) : '0;
  assign lb_push     = push_p0;
  assign lb_data     = push_p0 ? ifm_rd_data : '0;
  assign ofm_wr_en   = win_p1[KLAT-1];
  assign ofm_wr_addr = ofm_wr_en ? wr_base_q + AW'(wr_cnt) : '0;
  assign ofm_wr_data = ofm_wr_en ? conv_dout : '0;

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the 3x3 convolution datapath (3x3 line buffer feeding the 3x3 conv kernel).
- Reads a W x H ifmap from SRAM in row-major order, one pixel per cycle.
- Pushes each pixel into the line buffer and tracks which pushes complete a valid 3x3 window.
- Delays that window-valid flag by the kernel pipeline latency, then writes kernel results to ofmap SRAM at sequential addresses.
- Valid-only convolution: stride 1, no padding, output size (W-2) x (H-2). Runtime-configurable dims; start/busy/done control.

Parameters:
- AW, 16, SRAM address width (read and write).
- DW, 16, pixel and result data width.
- DIMW, 8, width of the cfg_width and cfg_height fields.
- KLAT, 2, cycles from the lb_push that completes a window to the matching conv_dout being valid (kernel latency, >=1).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request, sampled only in IDLE.
- abort  in  1  synchronous abort of a running job.
- cfg_width  in  DIMW  ifmap width W; sampled at launch.
- cfg_height  in  DIMW  ifmap height H; sampled at launch.
- cfg_rd_base  in  AW  ifmap base address; sampled at launch.
- cfg_wr_base  in  AW  ofmap base address; sampled at launch.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  one-cycle pulse when start is rejected for bad dims.
- ifm_rd_en  out  1  SRAM read strobe.
- ifm_rd_addr  out  AW  SRAM read address.
- ifm_rd_data  in  DW  SRAM read data, valid one cycle after ifm_rd_en.
- lb_push  out  1  line buffer shift enable.
- lb_data  out  DW  pixel to the line buffer.
- conv_dout  in  DW  kernel result.
- ofm_wr_en  out  1  ofmap write strobe.
- ofm_wr_addr  out  AW  ofmap write address.
- ofm_wr_data  out  DW  ofmap write data, equal to conv_dout in the same cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and delay lines cleared.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start with W>=3 and H>=3: latch cfg_*, set N = W*H (2*DIMW bits, no overflow), go to READ.
  - On start with W<3 or H<3: pulse cfg_err for one cycle, stay IDLE.
  - start is ignored in every other state.
- READ:
  - Cycle k = 0..N-1 of READ: ifm_rd_en=1, ifm_rd_addr = rd_base + k (modulo 2^AW).
  - After the cycle with k = N-1, go to DRAIN.
- Push path:
  - lb_push is ifm_rd_en delayed 1 cycle.
  - lb_data is driven from ifm_rd_data in that same cycle.
  - Row/col counters (r, c) advance on each push: c wraps at W-1 and then r increments.
- Window valid flag: set on a push when r>=2 and c>=2. It enters a KLAT-deep shift register.
- Write path:
  - ofm_wr_en is the flag output of that shift register.
  - ofm_wr_addr = wr_base + write count; the count increments after each write.
  - Total writes = (W-2)*(H-2).
- DRAIN: held until the push pipeline and the KLAT delay line are empty (last write issued), then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is 1 in READ, DRAIN and DONE.
- Latency: with start sampled at cycle 0, the last write is at cycle N+1+KLAT and done at cycle N+2+KLAT.
- Abort:
  - In READ, DRAIN or DONE: next cycle state IDLE.
  - All strobes, delay lines and counters are cleared and in-flight writes are dropped.
  - No done pulse; if abort coincides with DONE, done is still suppressed.
  - Abort in IDLE has no effect.
  - Abort and start in the same IDLE cycle: start wins.
- rst mid-job: same as abort, with all outputs forced to reset values next cycle.
- Back-to-back jobs: start may be asserted during the done cycle's following IDLE cycle; the earliest relaunch is the cycle after done.
- The line buffer row length is configured to W externally. This block guarantees a gapless push stream, with no bubbles inside a job.

Test Plan:
1. Nominal 4x4: W=4, H=4, rd_base=0x100, wr_base=0x200, KLAT=2, start at cycle 0.
   -> ifm_rd_en high cycles 1-16 (addr 0x100-0x10F); lb_push cycles 2-17.
   -> ofm_wr_en only at cycles 14, 15, 18, 19, with addr 0x200-0x203.
   -> done pulse at cycle 20; busy cycles 1-20.
2. Minimal 3x3: W=H=3.
   -> exactly one write, at cycle 12 (pixel 8 push at cycle 10, +KLAT), addr = wr_base.
   -> done at cycle 13.
3. Bad config: start with W=2, H=5.
   -> cfg_err one cycle, busy stays 0, no rd/wr strobes.
   -> A following start with W=5, H=5 runs normally, with 9 writes.
4. Abort in READ, at cycle 6 of a 4x4 job.
   -> busy=0, ifm_rd_en=0 and ofm_wr_en=0 from cycle 7 on; no done pulse.
   -> A new start then produces the full scenario-1 response.
5. Ignored start plus back-to-back: pulse start during READ -> no effect. Relaunch the cycle after done -> second job's read addresses restart at rd_base.
6. Address wrap and reset: rd_base=0xFFFE with a 3x3 job -> read addresses wrap to 0x0000-0x0006. Assert rst during DRAIN -> all outputs 0 next cycle, no done pulse.
